// File: rtl/alien_formation_ctrl.sv
// Formation controller for the alien sprites: alive mask, march direction/period, x/y offsets, armed pick.
// Optional macro FORMATION_SPEEDUP_EN: every accepted kill also shortens the march period.
module alien_formation_ctrl #(
  parameter int unsigned NUM_ALIENS   = 8,
  parameter logic [15:0] MAX_OFFSET_X = 16'd96,
  parameter logic [15:0] DROP_PIXELS  = 16'd8,
  parameter logic [15:0] INVADE_Y     = 16'd64,
  parameter logic [15:0] BASE_PERIOD  = 16'd1000,
  parameter logic [15:0] MIN_PERIOD   = 16'd50,
  parameter logic [15:0] EDGE_STEP    = 16'd50,
  parameter logic [15:0] KILL_STEP    = 16'd20,
  parameter logic [15:0] ARM_INTERVAL = 16'd4000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hit_valid,
  input  logic [3:0]            hit_index,
  output logic [NUM_ALIENS-1:0] alive_mask,
  output logic [15:0]           movement_frequency,
  output logic                  movement_direction,
  output logic [NUM_ALIENS-1:0] armed_mask,
  output logic [15:0]           offset_x,
  output logic [15:0]           offset_y,
  output logic                  wave_cleared,
  output logic                  invaded
);

  localparam int unsigned NA = NUM_ALIENS;
  localparam int unsigned DW = 16;

`ifdef FORMATION_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARCH,
    S_DROP,
    S_CLEARED,
    S_INVADED
  } state_e;

  state_e        state_q, state_d;
  logic [NA-1:0] alive_q, alive_d;
  logic [NA-1:0] armed_q, armed_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] per_q, per_d;
  logic [DW-1:0] offx_q, offx_d;
  logic [DW-1:0] offy_q, offy_d;
  logic [DW-1:0] mcnt_q, mcnt_d;
  logic [DW-1:0] acnt_q, acnt_d;
  logic [DW-1:0] lfsr_q, lfsr_d;
  logic          cleared_q, cleared_d;
  logic          invaded_q, invaded_d;

  logic          active;
  logic          shrink;
  logic [16:0]   step;
  logic [NA-1:0] hit_oh;
  logic [NA-1:0] kill_oh;
  logic [3:0]    arm_idx;

  // Saturating period reduction: never below MIN_PERIOD, never wraps.
  function automatic logic [DW-1:0] shorten(input logic [DW-1:0] per, input logic [16:0] dec);
    logic [17:0] diff;
    diff = {2'b00, per} - {1'b0, dec};
    if (diff[17] || diff[16] || (diff[15:0] < MIN_PERIOD)) shorten = MIN_PERIOD;
    else shorten = diff[15:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    alive_d   = alive_q;
    armed_d   = armed_q;
    dir_d     = dir_q;
    per_d     = per_q;
    offx_d    = offx_q;
    offy_d    = offy_q;
    mcnt_d    = mcnt_q;
    acnt_d    = acnt_q;
    lfsr_d    = lfsr_q;
    cleared_d = cleared_q;
    invaded_d = invaded_q;
    shrink    = 1'b0;
    step      = '0;
    arm_idx   = '0;
    active    = (state_q == S_MARCH) || (state_q == S_DROP);
    hit_oh    = NA'(1) << hit_index;
    kill_oh   = '0;
    if (hit_valid && active && ({1'b0, hit_index} < 5'(NA))) kill_oh = hit_oh & alive_q;

    if (start) begin
      state_d   = S_MARCH;
      alive_d   = '1;
      armed_d   = '0;
      dir_d     = 1'b1;
      per_d     = BASE_PERIOD;
      offx_d    = '0;
      offy_d    = '0;
      mcnt_d    = '0;
      acnt_d    = '0;
      cleared_d = 1'b0;
      invaded_d = 1'b0;
    end else begin
      case (state_q)
        S_MARCH: begin
          // Same tick rule as the alien instances so offsets stay in lockstep with the sprites.
          if (mcnt_q >= per_q) begin
            mcnt_d = '0;
            offx_d = dir_q ? (offx_q + 16'd1) : (offx_q - 16'd1);
            if (offx_d == (dir_q ? MAX_OFFSET_X : 16'd0)) state_d = S_DROP;
          end else begin
            mcnt_d = mcnt_q + 16'd1;
          end
        end
        S_DROP: begin
          offy_d  = offy_q + DROP_PIXELS;
          dir_d   = ~dir_q;
          shrink  = 1'b1;
          step    = 17'(EDGE_STEP);
          state_d = (offy_d >= INVADE_Y) ? S_INVADED : S_MARCH;
        end
        default: ;
      endcase

      if (active) begin
        alive_d = alive_q & ~kill_oh;
        if (SPEEDUP && (kill_oh != '0)) begin
          shrink = 1'b1;
          step   = step + 17'(KILL_STEP);
        end
        if (shrink) per_d = shorten(per_q, step);

        // Armed pick is masked by the next alive state so a killed armed alien drops at once.
        if (acnt_q >= (ARM_INTERVAL - 16'd1)) begin
          acnt_d  = '0;
          lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          arm_idx = 4'(lfsr_d % 16'(NA));
          armed_d = (NA'(1) << arm_idx) & alive_d;
        end else begin
          acnt_d  = acnt_q + 16'd1;
          armed_d = armed_q & alive_d;
        end

        if (alive_d == '0) begin
          state_d   = S_CLEARED;
          cleared_d = 1'b1;
          armed_d   = '0;
        end else if (state_d == S_INVADED) begin
          invaded_d = 1'b1;
          armed_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      alive_q   <= '0;
      armed_q   <= '0;
      dir_q     <= 1'b0;
      per_q     <= BASE_PERIOD;
      offx_q    <= '0;
      offy_q    <= '0;
      mcnt_q    <= '0;
      acnt_q    <= '0;
      lfsr_q    <= 16'hACE1;
      cleared_q <= 1'b0;
      invaded_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      armed_q   <= armed_d;
      dir_q     <= dir_d;
      per_q     <= per_d;
      offx_q    <= offx_d;
      offy_q    <= offy_d;
      mcnt_q    <= mcnt_d;
      acnt_q    <= acnt_d;
      lfsr_q    <= lfsr_d;
      cleared_q <= cleared_d;
      invaded_q <= invaded_d;
    end
  end

  assign alive_mask         = alive_q;
  assign armed_mask         = armed_q;
  assign movement_frequency = per_q;
  assign movement_direction = dir_q;
  assign offset_x           = offx_q;
  assign offset_y           = offy_q;
  assign wave_cleared       = cleared_q;
  assign invaded            = invaded_q;

endmodule
